// File: rtl/window_pkg.sv
// Shared types and width helpers for the 3x3 pixel window generator.
package window_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } win_state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_window_gen_line_delay.sv
// Line delay for the window generator: DEPTH-stage pixel shift register advanced on en.
module line_delay
    import window_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clock,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);

    pixel_t mem [DEPTH];

    // NOTE: the line storage is deliberately left unreset; stale contents are
    // always masked at the output until the new frame has overwritten them.
    always_ff @(posedge clock) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/pixel_window_gen.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, one zero-padded window per pixel out.
module pixel_window_gen
    import window_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48
) (
    input  logic   clock,
    input  logic   rst,
    input  pixel_t in_pixel,
    input  logic   in_valid,
    input  logic   in_sof,
    output logic   in_ready,
    output pixel_t pixel_pp,
    output pixel_t pixel_p0,
    output pixel_t pixel_pm,
    output pixel_t pixel_0p,
    output pixel_t pixel_0m,
    output pixel_t pixel_mp,
    output pixel_t pixel_m0,
    output pixel_t pixel_mm,
    output logic   on_edge,
    output logic   out_valid,
    output logic   out_eof
);

    localparam int IDX_W = cnt_width(IMG_W * IMG_H);
    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);
    localparam int DRN_W = cnt_width(IMG_W + 1);

    localparam logic [IDX_W-1:0] FILL_LAST  = IDX_W'(IMG_W);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(IMG_W * IMG_H - 1);
    localparam logic [DRN_W-1:0] DRN_LAST   = DRN_W'(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);

    win_state_t       state;
    logic [IDX_W-1:0] in_idx;
    logic [DRN_W-1:0] drn_cnt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    logic   accept, sof_acc, push, emit, last_drain;
    logic   m_row, p_row, m_col, p_col;
    pixel_t push_pix, ld1_out, ld2_out;
    pixel_t r0 [2];
    pixel_t r1 [2];
    pixel_t r2 [2];

    assign in_ready   = (state != DRAIN);
    assign accept     = in_valid && in_ready;
    assign sof_acc    = accept && in_sof;
    assign push       = (state == DRAIN) || (accept && (state != IDLE || in_sof));
    assign push_pix   = (state == DRAIN) ? pixel_t'(0) : in_pixel;
    assign emit       = (state == DRAIN) || (state == STREAM && accept && !in_sof);
    assign last_drain = (state == DRAIN) && (drn_cnt == DRN_LAST);

    // Delay line of 2*IMG_W+3 taps: three short rows joined by two line delays.
    line_delay #(.DEPTH(IMG_W)) u_line1 (.clock(clock), .en(push), .din(push_pix), .dout(ld1_out));
    line_delay #(.DEPTH(IMG_W)) u_line2 (.clock(clock), .en(push), .din(ld1_out),  .dout(ld2_out));

    always_ff @(posedge clock) begin
        if (push) begin
            r0[0] <= push_pix;
            r0[1] <= r0[0];
            r1[0] <= ld1_out;
            r1[1] <= r1[0];
            r2[0] <= ld2_out;
            r2[1] <= r2[0];
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= IDLE;
            in_idx  <= '0;
            drn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sof_acc) begin
                        in_idx <= IDX_W'(1);
                        state  <= FILL;
                    end
                end
                FILL, STREAM: begin
                    if (sof_acc) begin
                        in_idx <= IDX_W'(1);
                        state  <= FILL;
                    end else if (accept) begin
                        in_idx <= in_idx + 1'b1;
                        if (state == FILL && in_idx == FILL_LAST) begin
                            state <= STREAM;
                        end else if (state == STREAM && in_idx == FRAME_LAST) begin
                            state   <= DRAIN;
                            drn_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    drn_cnt <= drn_cnt + 1'b1;
                    if (last_drain) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Centre coordinates of the next window to be emitted.
    always_ff @(posedge clock) begin
        if (rst || sof_acc) begin
            row <= '0;
            col <= '0;
        end else if (emit) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign m_row = (row == '0);
    assign p_row = (row == ROW_LAST);
    assign m_col = (col == '0);
    assign p_col = (col == COL_LAST);

    // Taps are taken from the post-push values so the window lands one cycle after its pixel.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            on_edge   <= 1'b0;
            pixel_pp  <= '0;
            pixel_p0  <= '0;
            pixel_pm  <= '0;
            pixel_0p  <= '0;
            pixel_0m  <= '0;
            pixel_mp  <= '0;
            pixel_m0  <= '0;
            pixel_mm  <= '0;
        end else begin
            out_valid <= emit;
            out_eof   <= last_drain;
            on_edge   <= emit && (m_row || p_row || m_col || p_col);
            if (emit) begin
                pixel_pp <= (p_col || p_row) ? '0 : push_pix;
                pixel_0p <= p_row            ? '0 : r0[0];
                pixel_mp <= (m_col || p_row) ? '0 : r0[1];
                pixel_p0 <= p_col            ? '0 : ld1_out;
                pixel_m0 <= m_col            ? '0 : r1[1];
                pixel_pm <= (p_col || m_row) ? '0 : ld2_out;
                pixel_0m <= m_row            ? '0 : r2[0];
                pixel_mm <= (m_col || m_row) ? '0 : r2[1];
            end
        end
    end

endmodule

// File: doc/pixel_window_gen.md
Name: pixel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator upstream of the edge-detection core (dut_core).
- Accepts a raster-order pixel stream, one pixel per accepted beat.
- Emits one 3x3 window per pixel position, in the pixel_xy format the core consumes, with on_edge flagging border centres and zero padding for out-of-frame neighbours.
- Owns frame sequencing (fill, stream, drain) so the core sees exactly IMG_W*IMG_H windows per frame.

Parameters:
IMG_W, 64, pixels per line (>=3)
IMG_H, 48, lines per frame (>=2)

Ports:
clock  input  1  clock
rst  input  1  reset
in_pixel  input  8  raster pixel
in_valid  input  1  in_pixel valid
in_sof  input  1  first pixel of frame, qualified by in_valid
in_ready  output  1  block accepts in_pixel this cycle
pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm  output  8 each  window taps; first char = column offset, second = row offset; p=+1 (right/below), 0=centre, m=-1 (left/above)
on_edge  output  1  window centre on frame border
out_valid  output  1  window outputs valid this cycle
out_eof  output  1  last window of frame (centre IMG_H-1, IMG_W-1)

Behaviour:
- Reset: rst is synchronous and active-high; clock is clock. On reset: state=IDLE, in_ready=1, out_valid=0, out_eof=0, on_edge=0, all pixel_* outputs = 0, counters = 0.
- Reset mid-frame: the block returns to IDLE. No further out_valid until a new in_sof.
- Accept = in_valid && in_ready.
- Delay line: 2*IMG_W+3 taps. Newest pixel = pixel_pp; pixel_p0 = tap IMG_W; pixel_pm = tap 2*IMG_W; 0x column = tap+1; mx column = tap+2.
- States:
  - IDLE: in_ready=1. Accepted beats without in_sof are dropped. An accepted in_sof pixel is pushed, input index=1, and the block moves to FILL.
  - FILL: in_ready=1. The block pushes until IMG_W+1 pixels are accepted, with no output, then moves to STREAM.
  - STREAM: in_ready=1. Each accepted pixel (index k) produces the window centred at k-(IMG_W+1) on the next cycle (1-cycle registered latency). When pixel IMG_W*IMG_H-1 is accepted, the block moves to DRAIN.
  - DRAIN: in_ready=0. The block pushes IMG_W+1 internal zero pixels, one per cycle, each yielding one window. On the last one it asserts out_eof and moves to IDLE.
- Output count per frame is exactly IMG_W*IMG_H. out_valid has no gaps in DRAIN; in STREAM it follows in_valid gaps.
- Centre coordinates: (row, col) output counters advance on each emitted window, col wrapping at IMG_W-1.
- on_edge=1 iff row==0, row==IMG_H-1, col==0, or col==IMG_W-1.
- Masking (registered with the taps):
  - col==0 forces all m-column taps to 0.
  - col==IMG_W-1 forces all p-column taps to 0.
  - row==0 forces all m-row taps to 0.
  - row==IMG_H-1 forces all p-row taps to 0.
- in_sof accepted in FILL or STREAM: the current frame is abandoned with no out_eof. The block restarts as if from IDLE with this pixel as index 0. Stale taps are masked by the row-0 rule until overwritten.
- in_sof ignored in DRAIN (in_ready=0).
- out_valid, out_eof and on_edge are registered and deasserted whenever no window is emitted. pixel_* outputs hold their last values when out_valid=0.

Decomposition:
- Package window_pkg: typedef pixel_t (logic [7:0]); enum win_state_t {IDLE, FILL, STREAM, DRAIN}; localparam functions for counter widths ($clog2 of IMG_W, IMG_H, IMG_W*IMG_H).
- Sub-module line_delay: IMG_W-deep shift delay, pixel_t in/out, with enable. Instantiated twice between the three 3-tap rows.
- Top holds the FSM, counters, masking and output registers.

Test Plan:
- IMG_W=4, IMG_H=3, pixels 1..12 with in_sof on the first, continuous valid -> 12 windows. First window appears 1 cycle after the 6th accept, with centre 1, pixel_pp=6, pixel_mm=0, on_edge=1. Window for centre 6 (row1,col1): pp=11, p0=7, pm=3, 0p=10, 0m=2, mp=9, m0=5, mm=1, on_edge=0.
- Same frame -> DRAIN holds in_ready=0 for 5 cycles. Final window has centre 12, mp/pm/pp/0p/p0 all 0, out_eof=1 only on that window.
- Random in_valid gaps (50%) -> identical window sequence to the continuous case; out_valid never asserted without a preceding accept, except in DRAIN.
- Beats before any in_sof (values 0xAA) -> dropped, no out_valid; the frame after in_sof is unaffected.
- in_sof re-asserted at pixel 8 of a frame -> no out_eof for the old frame; new frame produces 12 windows with correct zero masking on row 0.
- rst pulsed during STREAM -> next cycle out_valid=0, in_ready=1, pixel_* = 0; following full frame correct.
